// File: rtl/mem_fill_arbiter.sv
// Unified-memory port arbiter: grants I-miss > D-store > D-miss and sequences block refills,
// issuing one read per cycle and steering returning words into the missing cache.
module mem_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               I_miss,
    input  logic [15:0]                        I_addr,
    input  logic                               D_miss,
    input  logic [15:0]                        D_addr,
    input  logic                               D_wr_req,
    input  logic [15:0]                        D_wr_addr,
    input  logic [15:0]                        D_wr_data,
    input  logic [15:0]                        mem_data_out,
    input  logic                               mem_data_valid,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [15:0]                        mem_addr,
    output logic [15:0]                        mem_data_in,
    output logic [15:0]                        fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic                               I_fill_we,
    output logic                               D_fill_we,
    output logic                               I_tag_we,
    output logic                               D_tag_we,
    output logic                               wr_ack,
    output logic                               fill_busy
);
    localparam int IDXW = $clog2(WORDS_PER_BLOCK);
    localparam int CW   = IDXW + 1;
    localparam logic [15:0] BLK_MASK = ~16'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0] WPB_C  = CW'(WORDS_PER_BLOCK);
    localparam logic [CW-1:0] LAST_C = CW'(WORDS_PER_BLOCK - 1);

    if ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 || WORDS_PER_BLOCK < 2 || MEM_LATENCY < 1)
    begin : g_param_chk
        $error("mem_fill_arbiter: WORDS_PER_BLOCK must be a power of 2 >= 2, MEM_LATENCY >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL_I, S_FILL_D} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_req_cnt;
    logic [CW-1:0]   r_rcv_cnt;
    logic [15:0]     r_base;

    state_t          w_state_nxt;
    logic            w_load_base;
    logic [15:0]     w_base_nxt;
    logic            w_issue;
    logic            w_recv;
    logic            w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_req_cnt <= '0;
            r_rcv_cnt <= '0;
            r_base    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_base)
                r_base <= w_base_nxt;
            // Final word closes the transaction, so both counters restart for the next grant
            if (w_last) begin
                r_req_cnt <= '0;
                r_rcv_cnt <= '0;
            end else begin
                if (w_issue)
                    r_req_cnt <= r_req_cnt + 1'b1;
                if (w_recv)
                    r_rcv_cnt <= r_rcv_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_base   = 1'b0;
        w_base_nxt    = r_base;
        w_issue       = 1'b0;
        w_recv        = 1'b0;
        w_last        = 1'b0;
        mem_en        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_data_in   = '0;
        fill_data     = '0;
        fill_word_idx = '0;
        I_fill_we     = 1'b0;
        D_fill_we     = 1'b0;
        I_tag_we      = 1'b0;
        D_tag_we      = 1'b0;
        wr_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_miss) begin
                    w_state_nxt = S_FILL_I;
                    w_load_base = 1'b1;
                    w_base_nxt  = I_addr & BLK_MASK;
                end else if (D_wr_req) begin
                    w_state_nxt = S_WRITE;
                    w_load_base = 1'b1;
                    w_base_nxt  = D_wr_addr & BLK_MASK;
                end else if (D_miss) begin
                    w_state_nxt = S_FILL_D;
                    w_load_base = 1'b1;
                    w_base_nxt  = D_addr & BLK_MASK;
                end
            end
            S_WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = D_wr_addr;
                mem_data_in = D_wr_data;
                wr_ack      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FILL_I, S_FILL_D: begin
                w_issue       = (r_req_cnt < WPB_C);
                mem_en        = w_issue;
                mem_addr      = w_issue ? r_base + (16'(r_req_cnt) << 1) : 16'h0000;
                fill_data     = mem_data_out;
                fill_word_idx = r_rcv_cnt[IDXW-1:0];
                w_recv        = mem_data_valid && (r_rcv_cnt < WPB_C);
                w_last        = w_recv && (r_rcv_cnt == LAST_C);
                I_fill_we     = w_recv && (r_state == S_FILL_I);
                D_fill_we     = w_recv && (r_state == S_FILL_D);
                I_tag_we      = w_last && (r_state == S_FILL_I);
                D_tag_we      = w_last && (r_state == S_FILL_D);
                if (w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign fill_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: transaction-level model checked every cycle, a latency-4 memory
// responder, cache agents that drop requests on tag_we/wr_ack, and literal timing expectations.
module tb_mem_fill_arbiter;
    localparam int WPB = 8;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_miss, D_miss, D_wr_req, mem_data_valid;
    logic [15:0] I_addr, D_addr, D_wr_addr, D_wr_data, mem_data_out;
    logic        mem_en, mem_wr, I_fill_we, D_fill_we, I_tag_we, D_tag_we, wr_ack, fill_busy;
    logic [15:0] mem_addr, mem_data_in, fill_data;
    logic [2:0]  fill_word_idx;

    mem_fill_arbiter #(.WORDS_PER_BLOCK(WPB), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .I_miss(I_miss), .I_addr(I_addr), .D_miss(D_miss), .D_addr(D_addr),
        .D_wr_req(D_wr_req), .D_wr_addr(D_wr_addr), .D_wr_data(D_wr_data),
        .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .fill_data(fill_data), .fill_word_idx(fill_word_idx),
        .I_fill_we(I_fill_we), .D_fill_we(D_fill_we), .I_tag_we(I_tag_we), .D_tag_we(D_tag_we),
        .wr_ack(wr_ack), .fill_busy(fill_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // memory responder state and event logs
    int          due_q[$];
    logic [15:0] rda_q[$];
    logic        spur;
    logic        seen_i, seen_d, seen_ack;
    int          iss_c[$], ifw_c[$], ifw_i[$], dfw_c[$], itag_c[$], dtag_c[$], ack_c[$];
    logic [15:0] iss_a[$], ack_a[$], ack_d[$];

    // model state: mode 0 idle, 1 store, 2 I fill, 3 D fill
    int          m_mode = 0, m_req = 0, m_rcv = 0, m_nxt;
    logic [15:0] m_base = '0;
    logic        e_en, e_wr, e_ack, e_ifw, e_dfw, e_itag, e_dtag, e_busy;
    logic [15:0] e_addr, e_din;
    logic [2:0]  e_idx;

    always @(negedge clk) begin
        {e_en, e_wr, e_ack, e_ifw, e_dfw, e_itag, e_dtag} = '0;
        e_addr = '0; e_din = '0; e_idx = '0;
        if (rst) begin
            m_mode = 0; m_req = 0; m_rcv = 0;
        end
        e_busy = (m_mode != 0);
        m_nxt  = m_mode;
        if (!rst) begin
            case (m_mode)
                0: begin
                    if (I_miss) begin m_nxt = 2; m_base = I_addr & 16'hFFF0; end
                    else if (D_wr_req) m_nxt = 1;
                    else if (D_miss) begin m_nxt = 3; m_base = D_addr & 16'hFFF0; end
                end
                1: begin
                    e_en = 1; e_wr = 1; e_addr = D_wr_addr; e_din = D_wr_data; e_ack = 1; m_nxt = 0;
                end
                default: begin
                    if (m_req < WPB) begin
                        e_en = 1; e_addr = m_base + 16'(2 * m_req); m_req++;
                    end
                    if (mem_data_valid && m_rcv < WPB) begin
                        e_idx = m_rcv[2:0];
                        if (m_mode == 2) e_ifw = 1; else e_dfw = 1;
                        if (m_rcv == WPB - 1) begin
                            if (m_mode == 2) e_itag = 1; else e_dtag = 1;
                            m_nxt = 0; m_req = 0; m_rcv = 0;
                        end else m_rcv++;
                    end
                end
            endcase
        end
        chk("mem_en", mem_en, e_en);
        chk("mem_wr", mem_wr, e_wr);
        chk("wr_ack", wr_ack, e_ack);
        chk("I_fill_we", I_fill_we, e_ifw);
        chk("D_fill_we", D_fill_we, e_dfw);
        chk("I_tag_we", I_tag_we, e_itag);
        chk("D_tag_we", D_tag_we, e_dtag);
        chk("fill_busy", fill_busy, e_busy);
        if (e_en) chk("mem_addr", mem_addr, e_addr);
        if (e_wr) chk("mem_data_in", mem_data_in, e_din);
        if (e_ifw || e_dfw) begin
            chk("fill_word_idx", fill_word_idx, e_idx);
            chk("fill_data", fill_data, mem_data_out);
        end
        m_mode = m_nxt;

        seen_i = I_tag_we; seen_d = D_tag_we; seen_ack = wr_ack;
        if (mem_en && !mem_wr) begin
            due_q.push_back(cyc + LAT); rda_q.push_back(mem_addr);
            iss_c.push_back(cyc); iss_a.push_back(mem_addr);
        end
        if (I_fill_we) begin ifw_c.push_back(cyc); ifw_i.push_back(int'(fill_word_idx)); end
        if (D_fill_we) dfw_c.push_back(cyc);
        if (I_tag_we) itag_c.push_back(cyc);
        if (D_tag_we) dtag_c.push_back(cyc);
        if (wr_ack) begin ack_c.push_back(cyc); ack_a.push_back(mem_addr); ack_d.push_back(mem_data_in); end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (seen_i) I_miss = 1'b0;
        if (seen_d) D_miss = 1'b0;
        if (seen_ack) D_wr_req = 1'b0;
        mem_data_valid = 1'b0;
        mem_data_out   = 16'h0000;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_data_valid = 1'b1;
            mem_data_out   = rda_q[0] ^ 16'hA5A5;
            void'(due_q.pop_front()); void'(rda_q.pop_front());
        end else if (spur) begin
            mem_data_valid = 1'b1;
            mem_data_out   = 16'hDEAD;
        end
    endtask

    task automatic clr_logs();
        iss_c.delete(); iss_a.delete(); ifw_c.delete(); ifw_i.delete(); dfw_c.delete();
        itag_c.delete(); dtag_c.delete(); ack_c.delete(); ack_a.delete(); ack_d.delete();
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int g;

    initial begin
        rst = 1'b1; spur = 1'b0;
        I_miss = 0; D_miss = 0; D_wr_req = 0; mem_data_valid = 0;
        I_addr = 0; D_addr = 0; D_wr_addr = 0; D_wr_data = 0; mem_data_out = 0;
        seen_i = 0; seen_d = 0; seen_ack = 0;
        repeat (2) step();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", fill_busy, 0);
        chk("rst_addr", mem_addr, 0);
        rst = 1'b0;
        step();

        // 1: single I fill, addresses 1230..123E, words on cycles 5-12, tag on 12
        clr_logs(); I_addr = 16'h1236; I_miss = 1; g = cyc;
        repeat (20) step();
        chk("t1_miss_dropped", I_miss, 0);
        chk("t1_n_issue", iss_c.size(), 8);
        chk("t1_n_fill", ifw_c.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_issue_cyc", at(iss_c, i), g + 1 + i);
            chk("t1_issue_addr", (i < iss_a.size()) ? iss_a[i] : 16'hFFFF, 16'h1230 + 16'(2 * i));
            chk("t1_fill_cyc", at(ifw_c, i), g + 5 + i);
            chk("t1_fill_idx", at(ifw_i, i), i);
        end
        chk("t1_tag_cyc", at(itag_c, 0), g + 12);
        chk("t1_no_d", dfw_c.size() + dtag_c.size(), 0);

        // 2: simultaneous I and D miss -> I first, one idle, then D from 8000
        clr_logs(); I_addr = 16'h2010; D_addr = 16'h8004; I_miss = 1; D_miss = 1; g = cyc;
        repeat (40) step();
        chk("t2_itag_cyc", at(itag_c, 0), g + 12);
        chk("t2_d_issue_cyc", at(iss_c, 8), g + 14);
        chk("t2_d_issue_addr", (iss_a.size() > 8) ? iss_a[8] : 16'hFFFF, 16'h8000);
        chk("t2_d_first_fill", at(dfw_c, 0), g + 18);
        chk("t2_dtag_cyc", at(dtag_c, 0), g + 25);
        chk("t2_n_dfill", dfw_c.size(), 8);
        chk("t2_misses_dropped", {I_miss, D_miss}, 0);

        // 3: store with D miss pending -> store first, then D fill of 4000
        clr_logs(); D_wr_addr = 16'h4002; D_wr_data = 16'hBEEF; D_wr_req = 1;
        D_addr = 16'h4006; D_miss = 1; g = cyc;
        repeat (30) step();
        chk("t3_ack_cnt", ack_c.size(), 1);
        chk("t3_ack_cyc", at(ack_c, 0), g + 1);
        chk("t3_ack_addr", (ack_a.size() > 0) ? ack_a[0] : 16'hFFFF, 16'h4002);
        chk("t3_ack_data", (ack_d.size() > 0) ? ack_d[0] : 16'hFFFF, 16'hBEEF);
        chk("t3_d_issue_cyc", at(iss_c, 0), g + 3);
        chk("t3_d_issue_addr", (iss_a.size() > 0) ? iss_a[0] : 16'hFFFF, 16'h4000);
        chk("t3_dtag_cyc", at(dtag_c, 0), g + 14);

        // 4: store arriving mid-fill waits for the fill to finish
        clr_logs(); I_addr = 16'h0100; I_miss = 1; g = cyc;
        repeat (3) step();
        D_wr_addr = 16'h0200; D_wr_data = 16'h1234; D_wr_req = 1;
        repeat (27) step();
        chk("t4_ack_cnt", ack_c.size(), 1);
        chk("t4_ack_cyc", at(ack_c, 0), g + 14);
        chk("t4_itag_cyc", at(itag_c, 0), g + 12);
        chk("t4_req_dropped", D_wr_req, 0);

        // 5: async reset on fill word 3 aborts at once
        clr_logs(); I_addr = 16'h5550; I_miss = 1; g = cyc;
        repeat (8) step();
        chk("t5_pre_fill_we", I_fill_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_fill_we", I_fill_we, 0);
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_busy", fill_busy, 0);
        chk("t5_rst_addr", mem_addr, 0);
        I_miss = 0;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("t5_no_tag", itag_c.size(), 0);
        chk("t5_n_fill", ifw_c.size(), 3);
        chk("t5_idle", fill_busy, 0);

        // 6: spurious valid in idle and after the eighth word
        clr_logs(); spur = 1;
        repeat (3) step();
        spur = 0; I_addr = 16'h7000; I_miss = 1; g = cyc;
        repeat (12) step();
        spur = 1;
        repeat (3) step();
        spur = 0;
        repeat (3) step();
        chk("t6_n_fill", ifw_c.size(), 8);
        chk("t6_last_fill_cyc", at(ifw_c, 7), g + 12);
        chk("t6_n_tag", itag_c.size(), 1);
        chk("t6_no_d", dfw_c.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
